line_tap_reader: RTL and testbench
==================================

// Module: line_tap_reader
// PURPOSE
//   VGA_CLK-side consumer of the 3-line rotating line buffer. Issues READ_Request/READ_Cont
//   for one display line per iLINE_START, captures the two buffered rows (taps0x, taps1x) and
//   emits a 2-row x 3-column pixel window per column, with edge replication, for the
//   downstream stereo/filter stage. Sits between VGA timing and the disparity/convolution logic.
// PARAMETERS
//   H_ACTIVE  640  pixels per line; READ_Cont runs 0..H_ACTIVE-1
//   RD_LAT    1    cycles from READ_Cont to valid taps (RAM read latency)
//   DW        10   pixel width; must match line buffer data width
//   AW        13   READ_Cont width
// PORTS
//   VGA_CLK       in   1      sole clock
//   RESET         in   1      synchronous, active-high
//   iLINE_START   in   1      1-cycle pulse (VGA_CLK domain): read the next line pair
//   iLINE_READY   in   1      level, pre-synchronised: writer holds >=2 completed lines
//   oREAD_Request out  1      to buffer READ_Request; taps read as 0 while low
//   oREAD_Cont    out  AW     to buffer READ_Cont (column address)
//   iTAPS0        in   DW     buffer taps0x (row r0)
//   iTAPS1        in   DW     buffer taps1x (row r1)
//   oWIN          out  6*DW   {r1c2,r1c1,r1c0,r0c2,r0c1,r0c0}; c1 = centre column
//   oWIN_VALID    out  1      oWIN/oWIN_X valid this cycle
//   oWIN_X        out  AW     column index of centre pixel
//   oBUSY         out  1      high in any state other than IDLE
//   oOVERRUN      out  1      sticky; cleared only by RESET
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, address counter 0, window regs 0.
//   FSM (registered, all transitions on VGA_CLK):
//     IDLE  : iLINE_START & iLINE_READY -> READ; iLINE_START & ~iLINE_READY -> WAIT
//     WAIT  : iLINE_READY -> READ (no timeout)
//     READ  : oREAD_Request=1, oREAD_Cont counts 0..H_ACTIVE-1, +1 per cycle;
//             after issuing H_ACTIVE-1 -> DRAIN
//     DRAIN : oREAD_Request held 1 for RD_LAT+2 cycles (taps gated by request), oREAD_Cont
//             held at H_ACTIVE-1; then -> IDLE, counter back to 0
//   iLINE_START while oBUSY: ignored, oOVERRUN set; current line completes undisturbed.
//   Timing: START sampled in IDLE at cycle T (READY high) -> oREAD_Cont=0 at T+1; data for
//     column a arrives at T+1+a+RD_LAT; oWIN_VALID high for exactly H_ACTIVE consecutive
//     cycles starting T+3+RD_LAT (T+4 default), oWIN_X = 0,1,..,H_ACTIVE-1.
//   Window: per row, 3-deep column shift; c0=x-1, c1=x, c2=x+1.
//     x=0: c0 := c1 (left replicate). x=H_ACTIVE-1: c2 := c1 (right replicate).
//   Pixel values pass through unmodified (no arithmetic); oWIN_X width AW, never wraps.
//   RESET mid-line: immediate abort, request drops next edge, no partial oWIN_VALID after.
//   Simultaneous RESET & iLINE_START: RESET wins, start discarded.
// STRUCTURE
//   Package line_tap_pkg: DW/AW defaults, FSM state encoding (IDLE/WAIT/READ/DRAIN),
//     window field offsets for oWIN slicing.
//   Sub-module line_tap_window: RD_LAT-aligned valid/x delay line + 2x3 shift registers +
//     edge replication; top holds FSM and address counter.
// TESTING
//   1 RESET, then START with READY=1, taps = column index -> 640 VALIDs from T+4, r0 window
//     at x=5 = {4,5,6}; x=0 = {0,0,1}; x=639 = {638,639,639}.
//   2 START with READY=0, READY raised 20 cycles later -> oREAD_Cont=0 the cycle after rise,
//     oBUSY high throughout the wait.
//   3 Second START during READ at x=300 -> oOVERRUN=1, still exactly 640 VALIDs, none extra.
//   4 RESET asserted at x=100 -> next cycle oREAD_Request=0, oWIN_VALID=0, oBUSY=0; new
//     START then yields a full clean 640-column line.
//   5 RD_LAT=2, H_ACTIVE=8, iTAPS0=0x3FF, iTAPS1=0x155 -> 8 VALIDs from T+5, all r0 fields
//     0x3FF, all r1 fields 0x155.
//   6 Back-to-back START pulses one cycle after return to IDLE -> second line accepted, no
//     overrun, VALID bursts separated by the drain gap only.

Source files
------------

// File: rtl/line_tap_reader_pkg.sv
// Shared definitions for the line tap reader: default sizes, read FSM
// encoding and the field layout of the 2x3 output window.
package line_tap_pkg;

    localparam int DW_DEF       = 10;
    localparam int AW_DEF       = 13;
    localparam int H_ACTIVE_DEF = 640;
    localparam int RD_LAT_DEF   = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Field index inside oWIN; field f occupies bits [f*DW +: DW].
    localparam int WIN_R0C0 = 0;
    localparam int WIN_R0C1 = 1;
    localparam int WIN_R0C2 = 2;
    localparam int WIN_R1C0 = 3;
    localparam int WIN_R1C1 = 4;
    localparam int WIN_R1C2 = 5;

    // Low bit of a window field for a given pixel width.
    function automatic int win_lo(input int field, input int dw);
        return field * dw;
    endfunction

endpackage

// File: rtl/line_tap_reader_window.sv
// Aligns issued column addresses with returning RAM data, keeps a 3-deep
// column history per row and emits the registered 2x3 window with edge
// replication at both ends of the line.
module line_tap_window
    import line_tap_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_col,
    input  logic [DW-1:0]   taps0,
    input  logic [DW-1:0]   taps1,
    output logic [6*DW-1:0] win,
    output logic            win_valid,
    output logic [AW-1:0]   win_x
);

    localparam logic [AW-1:0] LAST_COL = AW'(H_ACTIVE - 1);

    logic          dv_pipe_r [RD_LAT];
    logic [AW-1:0] da_pipe_r [RD_LAT];
    logic          tap_v_s;
    logic [AW-1:0] tap_col_s;
    logic [DW-1:0] r0_s2_r, r0_s1_r, r1_s2_r, r1_s1_r;
    logic          last_r;
    logic          nv_s;
    logic [AW-1:0] nx_s;
    logic [DW-1:0] r0c0_s, r0c1_s, r0c2_s, r1c0_s, r1c1_s, r1c2_s;
    logic [6*DW-1:0] win_r;
    logic          win_valid_r;
    logic [AW-1:0] win_x_r;

    assign tap_v_s   = dv_pipe_r[RD_LAT-1];
    assign tap_col_s = da_pipe_r[RD_LAT-1];

    // Delay the issued column tag by the RAM read latency so it lines up with the taps
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dv_pipe_r[i] <= 1'b0;
                da_pipe_r[i] <= {AW{1'b0}};
            end
        end else begin
            dv_pipe_r[0] <= issue_valid;
            da_pipe_r[0] <= issue_col;
            for (int i = 1; i < RD_LAT; i++) begin
                dv_pipe_r[i] <= dv_pipe_r[i-1];
                da_pipe_r[i] <= da_pipe_r[i-1];
            end
        end
    end

    // Next window: centre is one column behind the arriving tap; the final
    // column is emitted one cycle after its data, with the right edge replicated
    always_comb begin
        nv_s   = 1'b0;
        nx_s   = win_x_r;
        r0c0_s = win_r[WIN_R0C0*DW +: DW];
        r0c1_s = win_r[WIN_R0C1*DW +: DW];
        r0c2_s = win_r[WIN_R0C2*DW +: DW];
        r1c0_s = win_r[WIN_R1C0*DW +: DW];
        r1c1_s = win_r[WIN_R1C1*DW +: DW];
        r1c2_s = win_r[WIN_R1C2*DW +: DW];
        if (tap_v_s && (tap_col_s != {AW{1'b0}})) begin
            nv_s   = 1'b1;
            nx_s   = tap_col_s - AW'(1);
            r0c2_s = taps0;
            r0c1_s = r0_s2_r;
            r1c2_s = taps1;
            r1c1_s = r1_s2_r;
            if (tap_col_s == AW'(1)) begin
                r0c0_s = r0_s2_r;
                r1c0_s = r1_s2_r;
            end else begin
                r0c0_s = r0_s1_r;
                r1c0_s = r1_s1_r;
            end
        end else if (last_r) begin
            nv_s   = 1'b1;
            nx_s   = LAST_COL;
            r0c2_s = r0_s2_r;
            r0c1_s = r0_s2_r;
            r0c0_s = r0_s1_r;
            r1c2_s = r1_s2_r;
            r1c1_s = r1_s2_r;
            r1c0_s = r1_s1_r;
        end else begin
            nv_s = 1'b0;
        end
    end

    // Column history, last-column marker and registered window outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_s2_r     <= {DW{1'b0}};
            r0_s1_r     <= {DW{1'b0}};
            r1_s2_r     <= {DW{1'b0}};
            r1_s1_r     <= {DW{1'b0}};
            last_r      <= 1'b0;
            win_r       <= {(6*DW){1'b0}};
            win_valid_r <= 1'b0;
            win_x_r     <= {AW{1'b0}};
        end else begin
            last_r <= tap_v_s && (tap_col_s == LAST_COL);
            if (tap_v_s) begin
                r0_s2_r <= taps0;
                r0_s1_r <= r0_s2_r;
                r1_s2_r <= taps1;
                r1_s1_r <= r1_s2_r;
            end
            win_valid_r <= nv_s;
            win_x_r     <= nx_s;
            win_r       <= {r1c2_s, r1c1_s, r1c0_s, r0c2_s, r0c1_s, r0c0_s};
        end
    end

    assign win       = win_r;
    assign win_valid = win_valid_r;
    assign win_x     = win_x_r;

endmodule

// File: rtl/line_tap_reader.sv
// Display-side reader of the rotating line buffer: sequences one line of
// column reads per start pulse and hands the returning taps to the window stage.
module line_tap_reader
    import line_tap_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF
) (
    input  logic            VGA_CLK,
    input  logic            RESET,
    input  logic            iLINE_START,
    input  logic            iLINE_READY,
    output logic            oREAD_Request,
    output logic [AW-1:0]   oREAD_Cont,
    input  logic [DW-1:0]   iTAPS0,
    input  logic [DW-1:0]   iTAPS1,
    output logic [6*DW-1:0] oWIN,
    output logic            oWIN_VALID,
    output logic [AW-1:0]   oWIN_X,
    output logic            oBUSY,
    output logic            oOVERRUN
);

    localparam int DCW = (RD_LAT + 2 > 2) ? $clog2(RD_LAT + 2) : 1;
    localparam logic [AW-1:0]  LAST_COL   = AW'(H_ACTIVE - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RD_LAT + 1);

    state_t         state_r;
    logic [AW-1:0]  cont_r;
    logic           req_r;
    logic           ovr_r;
    logic [DCW-1:0] drain_cnt_r;

    // Read sequencer: line FSM, column address, buffer request and overrun flag
    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            cont_r      <= {AW{1'b0}};
            req_r       <= 1'b0;
            ovr_r       <= 1'b0;
            drain_cnt_r <= {DCW{1'b0}};
        end else begin
            if (iLINE_START && (state_r != ST_IDLE)) begin
                ovr_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (iLINE_START) begin
                        if (iLINE_READY) begin
                            state_r <= ST_READ;
                            req_r   <= 1'b1;
                            cont_r  <= {AW{1'b0}};
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (iLINE_READY) begin
                        state_r <= ST_READ;
                        req_r   <= 1'b1;
                        cont_r  <= {AW{1'b0}};
                    end
                end
                ST_READ: begin
                    if (cont_r == LAST_COL) begin
                        state_r     <= ST_DRAIN;
                        drain_cnt_r <= {DCW{1'b0}};
                    end else begin
                        cont_r <= cont_r + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    // Request stays up until the last tap has been captured
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                        cont_r  <= {AW{1'b0}};
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DCW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                    cont_r  <= {AW{1'b0}};
                end
            endcase
        end
    end

    assign oREAD_Request = req_r;
    assign oREAD_Cont    = cont_r;
    assign oBUSY         = (state_r != ST_IDLE);
    assign oOVERRUN      = ovr_r;

    line_tap_window #(
        .H_ACTIVE (H_ACTIVE),
        .RD_LAT   (RD_LAT),
        .DW       (DW),
        .AW       (AW)
    ) u_window (
        .clk         (VGA_CLK),
        .rst         (RESET),
        .issue_valid (state_r == ST_READ),
        .issue_col   (cont_r),
        .taps0       (iTAPS0),
        .taps1       (iTAPS1),
        .win         (oWIN),
        .win_valid   (oWIN_VALID),
        .win_x       (oWIN_X)
    );

endmodule

// File: tb/tb_line_tap_reader.sv
// Randomised bench for line_tap_reader: a RAM model feeds taps from row
// arrays; expected windows come from clamped array lookups per column.
module tb_line_tap_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_all, rst, start, ready, sel;
    logic [9:0] row0 [640];
    logic [9:0] row1 [640];
    int vec_cnt = 0;
    int err_cnt = 0;

    // DUT A: default geometry
    logic        a_req, a_valid, a_busy, a_ovr;
    logic [12:0] a_cont, a_x;
    logic [9:0]  a_t0, a_t1;
    logic [59:0] a_win;
    // DUT B: short line, two-cycle RAM
    logic        b_req, b_valid, b_busy, b_ovr;
    logic [12:0] b_cont, b_x;
    logic [9:0]  b_t0, b_t1;
    logic [59:0] b_win;

    line_tap_reader dut_a (
        .VGA_CLK(clk), .RESET(rst_all | (rst & ~sel)),
        .iLINE_START(start & ~sel), .iLINE_READY(ready),
        .oREAD_Request(a_req), .oREAD_Cont(a_cont),
        .iTAPS0(a_t0), .iTAPS1(a_t1), .oWIN(a_win), .oWIN_VALID(a_valid),
        .oWIN_X(a_x), .oBUSY(a_busy), .oOVERRUN(a_ovr));

    line_tap_reader #(.H_ACTIVE(8), .RD_LAT(2)) dut_b (
        .VGA_CLK(clk), .RESET(rst_all | (rst & sel)),
        .iLINE_START(start & sel), .iLINE_READY(ready),
        .oREAD_Request(b_req), .oREAD_Cont(b_cont),
        .iTAPS0(b_t0), .iTAPS1(b_t1), .oWIN(b_win), .oWIN_VALID(b_valid),
        .oWIN_X(b_x), .oBUSY(b_busy), .oOVERRUN(b_ovr));

    // Line buffer models: read latency 1 for A, 2 for B, taps zero without request
    logic [9:0] a_p0, a_p1, b_q0, b_q1, b_p0, b_p1;
    logic       a_pv, b_qv, b_pv;
    always @(posedge clk) begin
        a_p0 <= row0[int'(a_cont) % 640];
        a_p1 <= row1[int'(a_cont) % 640];
        a_pv <= a_req;
        b_q0 <= row0[int'(b_cont) % 640];
        b_q1 <= row1[int'(b_cont) % 640];
        b_qv <= b_req;
        b_p0 <= b_q0;
        b_p1 <= b_q1;
        b_pv <= b_qv;
    end
    assign a_t0 = a_pv ? a_p0 : 10'd0;
    assign a_t1 = a_pv ? a_p1 : 10'd0;
    assign b_t0 = b_pv ? b_p0 : 10'd0;
    assign b_t1 = b_pv ? b_p1 : 10'd0;

    // Observed outputs of whichever DUT is under test
    logic        req_m, valid_m, busy_m, ovr_m;
    logic [12:0] cont_m, x_m;
    logic [59:0] win_m;
    assign req_m   = sel ? b_req   : a_req;
    assign valid_m = sel ? b_valid : a_valid;
    assign busy_m  = sel ? b_busy  : a_busy;
    assign ovr_m   = sel ? b_ovr   : a_ovr;
    assign cont_m  = sel ? b_cont  : a_cont;
    assign x_m     = sel ? b_x     : a_x;
    assign win_m   = sel ? b_win   : a_win;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference window: neighbours clamped to the line, rows packed r1 over r0
    function automatic logic [59:0] exp_win(input int x, input int h);
        int l, r;
        l = (x > 0) ? x - 1 : 0;
        r = (x < h - 1) ? x + 1 : h - 1;
        return {row1[r], row1[x], row1[l], row0[r], row0[x], row0[l]};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 640; i++) begin
            row0[i] = 10'($urandom);
            row1[i] = 10'($urandom);
        end
    endtask

    // One line: start (now, at a negedge), optional ready delay, optional
    // second start at centre column ovr_x, optional reset at column rst_x
    task automatic run_line(input bit use_b, input int rdy_delay, input int ovr_x,
                            input int rst_x, input bit stop_idle, input bit exp_ovr);
        int h, lat, nvalid, kmax;
        bit done;
        h = use_b ? 8 : 640;
        lat = use_b ? 2 : 1;
        nvalid = 0;
        done = 1'b0;
        kmax = rdy_delay + h + 2 * lat + 8;
        sel = use_b;
        start = 1'b1;
        ready = (rdy_delay == 0);
        for (int k = 1; k <= kmax && !done; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (rst) begin
                check_eq("rst_req", 64'(req_m), 64'd0);
                check_eq("rst_valid", 64'(valid_m), 64'd0);
                check_eq("rst_busy", 64'(busy_m), 64'd0);
                rst = 1'b0;
                done = 1'b1;
            end else begin
                if (rdy_delay > 0 && k <= rdy_delay) begin
                    check_eq("wait_busy", 64'(busy_m), 64'd1);
                    check_eq("wait_req", 64'(req_m), 64'd0);
                    if (k == rdy_delay) ready = 1'b1;
                end
                if (rdy_delay > 0 && k == rdy_delay + 1) begin
                    check_eq("rise_req", 64'(req_m), 64'd1);
                    check_eq("rise_cont", 64'(cont_m), 64'd0);
                end
                if (valid_m) begin
                    if (nvalid == 0) check_eq("first_valid_cycle", 64'(k), 64'(rdy_delay + 3 + lat));
                    if (nvalid < h) begin
                        check_eq("win_x", 64'(x_m), 64'(nvalid));
                        check_eq("win", 64'(win_m), 64'(exp_win(nvalid, h)));
                    end else begin
                        check_eq("extra_valid", 64'd1, 64'd0);
                    end
                    if (nvalid == ovr_x) start = 1'b1;
                    if (nvalid == rst_x) rst = 1'b1;
                    nvalid++;
                end
                if (stop_idle && k > rdy_delay + 3 && !busy_m) done = 1'b1;
            end
        end
        if (rst_x < 0) check_eq("valid_count", 64'(nvalid), 64'(h));
        check_eq("end_busy", 64'(busy_m), 64'd0);
        check_eq("overrun", 64'(ovr_m), 64'(exp_ovr));
    endtask

    initial begin
        rst_all = 1'b1; rst = 1'b0; start = 1'b0; ready = 1'b0; sel = 1'b0;
        for (int i = 0; i < 640; i++) begin
            row0[i] = 10'(i);
            row1[i] = 10'(i);
        end
        repeat (3) @(negedge clk);
        rst_all = 1'b0;
        check_eq("reset_a", {a_req, a_valid, a_busy, a_ovr, a_cont, a_x}, 64'd0);
        check_eq("reset_a_win", 64'(a_win), 64'd0);
        check_eq("reset_b", {b_req, b_valid, b_busy, b_ovr, b_cont, b_x}, 64'd0);
        check_eq("reset_b_win", 64'(b_win), 64'd0);

        // Column-index taps, immediate ready
        run_line(1'b0, 0, -1, -1, 1'b0, 1'b0);
        // Ready raised 20 cycles after start
        fill_random();
        run_line(1'b0, 20, -1, -1, 1'b0, 1'b0);
        // Second start mid-line sets the sticky overrun
        fill_random();
        run_line(1'b0, 0, 300, -1, 1'b0, 1'b1);
        // Reset mid-line, then a clean line
        run_line(1'b0, 0, -1, 100, 1'b0, 1'b0);
        fill_random();
        run_line(1'b0, 0, -1, -1, 1'b0, 1'b0);
        // Back-to-back lines, restart as soon as the reader is idle
        fill_random();
        run_line(1'b0, 0, -1, -1, 1'b1, 1'b0);
        fill_random();
        run_line(1'b0, 0, -1, -1, 1'b1, 1'b0);
        // Short line, two-cycle RAM, constant taps
        for (int i = 0; i < 640; i++) begin
            row0[i] = 10'h3FF;
            row1[i] = 10'h155;
        end
        run_line(1'b1, 0, -1, -1, 1'b0, 1'b0);
        // Random short lines with random ready delays
        for (int n = 0; n < 6; n++) begin
            fill_random();
            run_line(1'b1, int'($urandom_range(0, 5)), -1, -1, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
